// File: rtl/mc_ctrl_hs.sv
// Multi-cycle MIPS controller with memory handshake, bus watchdog, illegal-opcode trap and retire counter.
// Latency: 3-5 states per instruction plus any memory wait cycles; outputs are combinational from the registered state.
// Backpressure: mem_ready stalls S_IF/S_MEM with requests held; the watchdog traps after TIMEOUT stalled cycles.
module mc_ctrl_hs #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32,
    parameter bit EN_BYTE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             zero,
    input  logic             neg,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [4:0]       rt,
    input  logic             mem_ready,
    output logic [1:0]       reg_dst,
    output logic             alu_src,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       ext_op,
    output logic [2:0]       alu_ctr,
    output logic             byte_sel,
    output logic [1:0]       npc_sel,
    output logic             pc_wr,
    output logic             ir_wr,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ifetch,
    output logic             illegal,
    output logic             timeout,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J   = 6'h02, OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_ADDI   = 6'h08, OP_ADDIU = 6'h09, OP_ORI = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f, OP_LB     = 6'h20, OP_LW  = 6'h23, OP_SB  = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_JR = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_SLT = 6'h2a;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;

    localparam logic [2:0] ALU_PASSB = 3'b000, ALU_ADD = 3'b001, ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_SLT   = 3'b011, ALU_OR  = 3'b100;
    localparam logic [1:0] EXT_LUI = 2'b01, EXT_SIGN = 2'b10;

    // Wait counter only has to reach TIMEOUT-1; one bit suffices when the watchdog is off.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT > 0) ? WAIT_W'(TIMEOUT - 1) : '0;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  count_q;
    logic              illegal_q, timeout_q;

    logic is_alu, is_load, is_store, is_beq, is_j, is_jr, is_jal, is_bltzal, legal;
    logic [1:0] dec_reg_dst, dec_mem_to_reg, dec_ext_op;
    logic [2:0] dec_alu_ctr;
    logic       dec_alu_src, dec_byte;
    logic       wd_hit, retire, set_illegal, set_timeout;
    logic       pc_wr_c, ir_wr_c, reg_write_c, mem_read_c, mem_write_c, ifetch_c, strobe_en;
    logic [1:0] npc_c;

    // Instruction decode straight from the IR fields.
    always_comb begin
        is_alu = 1'b0; is_load = 1'b0; is_store = 1'b0; is_beq = 1'b0;
        is_j = 1'b0; is_jr = 1'b0; is_jal = 1'b0; is_bltzal = 1'b0;
        dec_reg_dst = 2'b00; dec_alu_src = 1'b0; dec_mem_to_reg = 2'b00;
        dec_ext_op = 2'b00; dec_alu_ctr = ALU_PASSB; dec_byte = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dec_reg_dst = 2'b01;
                case (funct)
                    FN_ADDU: begin is_alu = 1'b1; dec_alu_ctr = ALU_ADD; end
                    FN_SUBU: begin is_alu = 1'b1; dec_alu_ctr = ALU_SUB; end
                    FN_SLT:  begin is_alu = 1'b1; dec_alu_ctr = ALU_SLT; end
                    FN_JR:   is_jr = 1'b1;
                    default: ;
                endcase
            end
            OP_ORI: begin is_alu = 1'b1; dec_alu_src = 1'b1; dec_alu_ctr = ALU_OR; end
            OP_LUI: begin is_alu = 1'b1; dec_alu_src = 1'b1; dec_ext_op = EXT_LUI; end
            OP_ADDI, OP_ADDIU: begin
                is_alu = 1'b1; dec_alu_src = 1'b1; dec_ext_op = EXT_SIGN; dec_alu_ctr = ALU_ADD;
            end
            OP_LW: begin
                is_load = 1'b1; dec_alu_src = 1'b1; dec_ext_op = EXT_SIGN;
                dec_alu_ctr = ALU_ADD; dec_mem_to_reg = 2'b01;
            end
            OP_SW: begin
                is_store = 1'b1; dec_alu_src = 1'b1; dec_ext_op = EXT_SIGN; dec_alu_ctr = ALU_ADD;
            end
            OP_LB: if (EN_BYTE) begin
                is_load = 1'b1; dec_alu_src = 1'b1; dec_ext_op = EXT_SIGN;
                dec_alu_ctr = ALU_ADD; dec_mem_to_reg = 2'b01; dec_byte = 1'b1;
            end
            OP_SB: if (EN_BYTE) begin
                is_store = 1'b1; dec_alu_src = 1'b1; dec_ext_op = EXT_SIGN;
                dec_alu_ctr = ALU_ADD; dec_byte = 1'b1;
            end
            OP_BEQ: begin is_beq = 1'b1; dec_alu_ctr = ALU_SUB; end
            OP_J:   is_j = 1'b1;
            OP_JAL: begin is_jal = 1'b1; dec_reg_dst = 2'b10; dec_mem_to_reg = 2'b10; end
            OP_REGIMM: if (rt == RT_BLTZAL) begin
                is_bltzal = 1'b1; dec_reg_dst = 2'b10; dec_mem_to_reg = 2'b10;
            end
            default: ;
        endcase
    end

    assign legal  = is_alu | is_load | is_store | is_beq | is_j | is_jr | is_jal | is_bltzal;
    assign wd_hit = (TIMEOUT > 0) && (wait_q == WAIT_LAST) && !mem_ready;

    // Next state, wait counter, retire and sticky-flag set conditions.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:   if (mem_ready) state_d = S_ID; else if (wd_hit) state_d = S_TRAP;
            S_ID:   if (!legal) state_d = S_TRAP;
                    else if (is_jal || is_bltzal) state_d = S_WB;
                    else state_d = S_EX;
            S_EX:   if (is_alu) state_d = S_WB;
                    else if (is_load || is_store) state_d = S_MEM;
                    else state_d = S_IF;
            S_MEM:  if (mem_ready) state_d = is_store ? S_IF : S_WB;
                    else if (wd_hit) state_d = S_TRAP;
            S_WB:   state_d = S_IF;
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IF;
        endcase
        if (state_d != state_q) wait_d = '0;
        else if (state_q == S_IF || state_q == S_MEM) wait_d = wait_q + WAIT_W'(1);
        else wait_d = wait_q;
        retire      = (state_d == S_IF) && (state_q == S_EX || state_q == S_MEM || state_q == S_WB);
        set_illegal = (state_q == S_ID) && (state_d == S_TRAP);
        set_timeout = (state_q == S_IF || state_q == S_MEM) && (state_d == S_TRAP);
    end

    // Control register update; reset drops straight back to fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IF;
            wait_q    <= '0;
            count_q   <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (retire)      count_q   <= count_q + CNT_W'(1);
            if (set_illegal) illegal_q <= 1'b1;
            if (set_timeout) timeout_q <= 1'b1;
        end
    end

    // Per-state strobes and next-PC select.
    always_comb begin
        pc_wr_c = 1'b0; ir_wr_c = 1'b0; reg_write_c = 1'b0;
        mem_read_c = 1'b0; mem_write_c = 1'b0; ifetch_c = 1'b0; npc_c = 2'b00;
        case (state_q)
            S_IF: begin
                mem_read_c = 1'b1; ifetch_c = 1'b1;
                if (mem_ready) begin ir_wr_c = 1'b1; pc_wr_c = 1'b1; end
            end
            S_EX: begin
                if (is_beq)     begin pc_wr_c = zero; npc_c = 2'b01; end
                else if (is_j)  begin pc_wr_c = 1'b1; npc_c = 2'b10; end
                else if (is_jr) begin pc_wr_c = 1'b1; npc_c = 2'b11; end
            end
            S_MEM: begin mem_read_c = is_load; mem_write_c = is_store; end
            S_WB: begin
                reg_write_c = 1'b1;
                if (is_jal)         begin pc_wr_c = 1'b1; npc_c = 2'b10; end
                else if (is_bltzal) begin pc_wr_c = neg;  npc_c = 2'b01; end
            end
            default: ;
        endcase
    end

    // Nothing may strobe while reset is low or once trapped.
    assign strobe_en = reset && (state_q != S_TRAP);
    assign pc_wr     = pc_wr_c     & strobe_en;
    assign ir_wr     = ir_wr_c     & strobe_en;
    assign reg_write = reg_write_c & strobe_en;
    assign mem_read  = mem_read_c  & strobe_en;
    assign mem_write = mem_write_c & strobe_en;
    assign ifetch    = ifetch_c    & strobe_en;
    assign npc_sel   = npc_c;

    // Decode fields are meaningless during fetch, so present them as zero there.
    assign reg_dst    = (state_q == S_IF) ? 2'b00 : dec_reg_dst;
    assign alu_src    = (state_q == S_IF) ? 1'b0  : dec_alu_src;
    assign mem_to_reg = (state_q == S_IF) ? 2'b00 : dec_mem_to_reg;
    assign ext_op     = (state_q == S_IF) ? 2'b00 : dec_ext_op;
    assign alu_ctr    = (state_q == S_IF) ? 3'b000 : dec_alu_ctr;
    assign byte_sel   = (state_q == S_IF) ? 1'b0  : dec_byte;

    assign illegal     = illegal_q;
    assign timeout     = timeout_q;
    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Bench for mc_ctrl_hs: directed scenarios plus random instruction streams with random memory waits.
// Expected state paths and strobes come from a per-instruction-class path model.
// A second instance with byte ops disabled checks lb trapping.
module tb_mc_ctrl_hs;

    localparam int S_IF = 0, S_ID = 1, S_EX = 2, S_MEM = 3, S_WB = 4, S_TRAP = 5;
    localparam logic [2:0] C_ALU = 0, C_LD = 1, C_ST = 2, C_BEQ = 3, C_J = 4, C_JR = 5, C_JAL = 6, C_BLZ = 7;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic [4:0] rt;
        logic [2:0] cls;
        logic [1:0] rd;
        logic       src;
        logic [1:0] m2r;
        logic [1:0] ext;
        logic [2:0] alu;
        logic       bsel;
    } ins_t;

    logic clk = 1'b0;
    logic reset, zero, neg, mem_ready;
    logic [5:0] opcode, funct;
    logic [4:0] rt;

    logic [1:0] reg_dst, mem_to_reg, ext_op, npc_sel;
    logic [2:0] alu_ctr, state;
    logic alu_src, byte_sel, pc_wr, ir_wr, reg_write, mem_read, mem_write, ifetch, illegal, timeout;
    logic [31:0] instr_count;

    logic [1:0] nb_reg_dst, nb_mem_to_reg, nb_ext_op, nb_npc_sel;
    logic [2:0] nb_alu_ctr, nb_state;
    logic nb_alu_src, nb_byte_sel, nb_pc_wr, nb_ir_wr, nb_reg_write, nb_mem_read, nb_mem_write;
    logic nb_ifetch, nb_illegal, nb_timeout;
    logic [31:0] nb_instr_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_count;

    mc_ctrl_hs #(.TIMEOUT(16), .CNT_W(32), .EN_BYTE(1'b1)) dut (
        .clk(clk), .reset(reset), .zero(zero), .neg(neg), .opcode(opcode), .funct(funct), .rt(rt),
        .mem_ready(mem_ready), .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .ext_op(ext_op), .alu_ctr(alu_ctr), .byte_sel(byte_sel), .npc_sel(npc_sel), .pc_wr(pc_wr),
        .ir_wr(ir_wr), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .ifetch(ifetch), .illegal(illegal), .timeout(timeout), .state(state), .instr_count(instr_count)
    );

    mc_ctrl_hs #(.TIMEOUT(16), .CNT_W(32), .EN_BYTE(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .zero(zero), .neg(neg), .opcode(opcode), .funct(funct), .rt(rt),
        .mem_ready(mem_ready), .reg_dst(nb_reg_dst), .alu_src(nb_alu_src), .mem_to_reg(nb_mem_to_reg),
        .ext_op(nb_ext_op), .alu_ctr(nb_alu_ctr), .byte_sel(nb_byte_sel), .npc_sel(nb_npc_sel),
        .pc_wr(nb_pc_wr), .ir_wr(nb_ir_wr), .reg_write(nb_reg_write), .mem_read(nb_mem_read),
        .mem_write(nb_mem_write), .ifetch(nb_ifetch), .illegal(nb_illegal), .timeout(nb_timeout),
        .state(nb_state), .instr_count(nb_instr_count)
    );

    always #5 clk = ~clk;

    wire [5:0]  obs_strb = {pc_wr, ir_wr, reg_write, mem_read, mem_write, ifetch};
    wire [12:0] obs_dec  = {reg_dst, alu_src, mem_to_reg, ext_op, alu_ctr, byte_sel, npc_sel};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Instruction table: encoding, class and the decode fields each instruction must show.
    function automatic ins_t get_ins(input int i);
        case (i)
            0:  return '{6'h00, 6'h21, 5'd0,  C_ALU, 2'b01, 1'b0, 2'b00, 2'b00, 3'b001, 1'b0}; // addu
            1:  return '{6'h00, 6'h23, 5'd0,  C_ALU, 2'b01, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0}; // subu
            2:  return '{6'h00, 6'h2a, 5'd0,  C_ALU, 2'b01, 1'b0, 2'b00, 2'b00, 3'b011, 1'b0}; // slt
            3:  return '{6'h00, 6'h08, 5'd0,  C_JR,  2'b01, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0}; // jr
            4:  return '{6'h0d, 6'h00, 5'd0,  C_ALU, 2'b00, 1'b1, 2'b00, 2'b00, 3'b100, 1'b0}; // ori
            5:  return '{6'h23, 6'h00, 5'd0,  C_LD,  2'b00, 1'b1, 2'b01, 2'b10, 3'b001, 1'b0}; // lw
            6:  return '{6'h2b, 6'h00, 5'd0,  C_ST,  2'b00, 1'b1, 2'b00, 2'b10, 3'b001, 1'b0}; // sw
            7:  return '{6'h04, 6'h00, 5'd0,  C_BEQ, 2'b00, 1'b0, 2'b00, 2'b00, 3'b010, 1'b0}; // beq
            8:  return '{6'h0f, 6'h00, 5'd0,  C_ALU, 2'b00, 1'b1, 2'b00, 2'b01, 3'b000, 1'b0}; // lui
            9:  return '{6'h02, 6'h00, 5'd0,  C_J,   2'b00, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0}; // j
            10: return '{6'h03, 6'h00, 5'd0,  C_JAL, 2'b10, 1'b0, 2'b10, 2'b00, 3'b000, 1'b0}; // jal
            11: return '{6'h08, 6'h00, 5'd0,  C_ALU, 2'b00, 1'b1, 2'b00, 2'b10, 3'b001, 1'b0}; // addi
            12: return '{6'h09, 6'h00, 5'd0,  C_ALU, 2'b00, 1'b1, 2'b00, 2'b10, 3'b001, 1'b0}; // addiu
            13: return '{6'h20, 6'h00, 5'd0,  C_LD,  2'b00, 1'b1, 2'b01, 2'b10, 3'b001, 1'b1}; // lb
            14: return '{6'h28, 6'h00, 5'd0,  C_ST,  2'b00, 1'b1, 2'b00, 2'b10, 3'b001, 1'b1}; // sb
            default: return '{6'h01, 6'h00, 5'h10, C_BLZ, 2'b10, 1'b0, 2'b10, 2'b00, 3'b000, 1'b0}; // bltzal
        endcase
    endfunction

    // Run one instruction from S_IF: d1 fetch wait cycles, d2 data wait cycles.
    task automatic run_instr(input ins_t in, input int d1, input int d2, input bit z, input bit n);
        int  st_q[$];
        bit  rd_q[$];
        int  st;
        bit  r, ewr;
        logic [1:0] enpc;
        for (int i = 0; i < d1; i++) begin st_q.push_back(S_IF); rd_q.push_back(1'b0); end
        st_q.push_back(S_IF); rd_q.push_back(1'b1);
        st_q.push_back(S_ID); rd_q.push_back(1'($urandom_range(0, 1)));
        if (in.cls != C_JAL && in.cls != C_BLZ) begin
            st_q.push_back(S_EX); rd_q.push_back(1'($urandom_range(0, 1)));
        end
        if (in.cls == C_LD || in.cls == C_ST) begin
            for (int i = 0; i < d2; i++) begin st_q.push_back(S_MEM); rd_q.push_back(1'b0); end
            st_q.push_back(S_MEM); rd_q.push_back(1'b1);
        end
        if (in.cls == C_ALU || in.cls == C_LD || in.cls == C_JAL || in.cls == C_BLZ) begin
            st_q.push_back(S_WB); rd_q.push_back(1'($urandom_range(0, 1)));
        end
        opcode = in.op;
        funct  = (in.op == 6'h00) ? in.fn : 6'($urandom);
        rt     = (in.op == 6'h01) ? in.rt : 5'($urandom);
        zero   = z;
        neg    = n;
        for (int k = 0; k < st_q.size(); k++) begin
            st = st_q[k];
            r  = rd_q[k];
            mem_ready = r;
            ewr = (st == S_IF && r)
                || (st == S_EX && ((in.cls == C_BEQ) ? z : (in.cls == C_J || in.cls == C_JR)))
                || (st == S_WB && (in.cls == C_JAL || (in.cls == C_BLZ && n)));
            enpc = 2'b00;
            if (st == S_EX && in.cls == C_BEQ) enpc = 2'b01;
            if (st == S_EX && in.cls == C_J)   enpc = 2'b10;
            if (st == S_EX && in.cls == C_JR)  enpc = 2'b11;
            if (st == S_WB && in.cls == C_JAL) enpc = 2'b10;
            if (st == S_WB && in.cls == C_BLZ) enpc = 2'b01;
            #1;
            chk("path_state", state, st);
            chk("strobes", obs_strb, {ewr, (st == S_IF && r), (st == S_WB),
                                      (st == S_IF || (st == S_MEM && in.cls == C_LD)),
                                      (st == S_MEM && in.cls == C_ST), (st == S_IF)});
            chk("decode", obs_dec, (st == S_IF) ? 13'd0
                : {in.rd, in.src, in.m2r, in.ext, in.alu, in.bsel, enpc});
            tick();
        end
        exp_count = exp_count + 1;
        #1;
        chk("back_to_if", state, S_IF);
        chk("instr_count", instr_count, exp_count);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rst_state", state, S_IF);
        chk("rst_strobes", obs_strb, 6'd0);
        chk("rst_decode", obs_dec, 13'd0);
        chk("rst_count", instr_count, 32'd0);
        chk("rst_flags", {illegal, timeout}, 2'b00);
        tick();
        reset = 1'b1;
        exp_count = 0;
    endtask

    initial begin
        reset = 1'b1; zero = 1'b0; neg = 1'b0; mem_ready = 1'b0;
        opcode = 6'h00; funct = 6'h21; rt = 5'd0;
        exp_count = 0;
        #2;
        do_reset();

        // addu with immediate memory, lw with 3 data wait cycles
        run_instr(get_ins(0), 0, 0, 1'b0, 1'b0);
        run_instr(get_ins(5), 0, 3, 1'b0, 1'b0);
        // beq not taken then taken; bltzal with neg low then high
        run_instr(get_ins(7), 0, 0, 1'b0, 1'b0);
        run_instr(get_ins(7), 1, 0, 1'b1, 1'b0);
        run_instr(get_ins(15), 0, 0, 1'b1, 1'b0);
        run_instr(get_ins(15), 0, 0, 1'b0, 1'b1);

        // fetch watchdog: 16 stalled cycles then trap
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("wd_if_wait", {state, obs_strb}, {3'(S_IF), 6'b000101});
            tick();
        end
        #1;
        chk("wd_trap_state", state, S_TRAP);
        chk("wd_trap_flags", {timeout, illegal}, 2'b10);
        chk("wd_trap_strobes", obs_strb, 6'd0);
        mem_ready = 1'b1;
        tick();
        #1;
        chk("trap_absorb", {state, obs_strb}, {3'(S_TRAP), 6'd0});
        do_reset();
        // ready arriving on the last allowed cycle wins
        run_instr(get_ins(0), 15, 0, 1'b0, 1'b0);
        #1;
        chk("wd_edge_no_trap", timeout, 1'b0);

        // data-phase watchdog
        do_reset();
        opcode = 6'h23; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("wd_mem_wait", {state, obs_strb}, {3'(S_MEM), 6'b000100});
            tick();
        end
        #1;
        chk("wd_mem_trap", {state, timeout}, {3'(S_TRAP), 1'b1});

        // illegal opcode
        do_reset();
        opcode = 6'h3f; mem_ready = 1'b1;
        tick();
        #1;
        chk("ill_id", {state, illegal}, {3'(S_ID), 1'b0});
        tick();
        #1;
        chk("ill_trap", {state, illegal, timeout, obs_strb}, {3'(S_TRAP), 1'b1, 1'b0, 6'd0});

        // lb is legal with byte ops, illegal without
        do_reset();
        opcode = 6'h20; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        #1;
        chk("lb_en_byte", state, S_EX);
        chk("lb_no_byte", {nb_state, nb_illegal}, {3'(S_TRAP), 1'b1});

        // reset in the middle of a stalled store
        do_reset();
        run_instr(get_ins(0), 0, 0, 1'b0, 1'b0);
        opcode = 6'h2b; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        tick();
        #1;
        chk("sw_mem_pending", {state, mem_write}, {3'(S_MEM), 1'b1});
        reset = 1'b0;
        #1;
        chk("midrst_state", state, S_IF);
        chk("midrst_strobes", obs_strb, 6'd0);
        chk("midrst_count", {instr_count, illegal, timeout}, {32'd0, 2'b00});
        tick();
        reset = 1'b1;
        exp_count = 0;

        // random instruction stream
        for (int n = 0; n < 60; n++) begin
            run_instr(get_ins($urandom_range(0, 15)), $urandom_range(0, 5), $urandom_range(0, 5),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        #1;
        chk("rand_flags", {illegal, timeout}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_hs.md
Name: mc_ctrl_hs

Overview:
Successor to the multi-cycle MIPS controller FSM. It adds a memory ready/handshake on instruction fetch and data access, a parametrised bus-timeout watchdog, illegal-opcode trapping, encoded next-PC selection and a retired-instruction counter. It sits between the IR/ALU datapath and the unified memory port of the multi-cycle CPU. Decode inputs come straight from the IR and are valid from S_ID onward.

Parameters:
TIMEOUT, 16, max cycles waiting for mem_ready in S_IF/S_MEM before trapping; 0 disables the watchdog.
CNT_W, 32, width of instr_count.
EN_BYTE, 1, 1 means lb/sb are supported; 0 means they decode as illegal.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
zero  in  1  ALU result == 0
neg  in  1  rs sign bit (for bltzal)
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
rt  in  5  IR[20:16]
mem_ready  in  1  memory completes the current access this cycle
reg_dst  out  2  00 rt, 01 rd, 10 $31
alu_src  out  1  1 selects the extended immediate
mem_to_reg  out  2  00 ALU, 01 memory, 10 PC+4
ext_op  out  2  00 zero-extend, 01 lui shift, 10 sign-extend
alu_ctr  out  3  000 pass-B, 001 add, 010 sub, 011 slt, 100 or
byte_sel  out  1  byte access (lb/sb)
npc_sel  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs
pc_wr  out  1  PC write strobe
ir_wr  out  1  IR write strobe
reg_write  out  1  register-file write strobe
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ifetch  out  1  current request is an instruction fetch
illegal  out  1  sticky: an unsupported opcode trapped
timeout  out  1  sticky: the watchdog expired
state  out  3  current state, for debug
instr_count  out  CNT_W  retired-instruction count

Behaviour:
- States: S_IF=0, S_ID=1, S_EX=2, S_MEM=3, S_WB=4, S_TRAP=5. Registered state; outputs are combinational from state, decode, zero, neg and mem_ready.
- Reset (reset=0, asynchronous): state=S_IF, wait counter=0, instr_count=0, illegal=0, timeout=0. While reset=0 every strobe (pc_wr, ir_wr, reg_write, mem_read, mem_write, ifetch) is forced to 0. Decode outputs are don't-care, but the bench expects 0 when state is S_IF.
- Supported instructions: addu, subu, slt, jr (opcode 0 plus funct); ori, lw, sw, beq, lui, j, jal, addi, addiu; lb, sb when EN_BYTE=1; bltzal (opcode 1, rt=10000). Any other encoding is illegal.
- Decode outputs are held stable from S_ID to the end of the instruction:
  - reg_dst=01 for R-type; 10 for jal/bltzal.
  - alu_src for ori/lw/sw/lui/addi/addiu/lb/sb.
  - ext_op=10 for loads, stores and addi/addiu; 01 for lui.
  - alu_ctr=001 for addu/addi/addiu and all loads/stores; 010 for subu/beq; 011 for slt; 100 for ori; 000 for lui.
  - byte_sel for lb/sb.
- S_IF: mem_read=1, ifetch=1.
  - mem_ready=1: ir_wr=1, pc_wr=1, npc_sel=00, next state S_ID.
  - Otherwise stay in S_IF and increment the wait counter.
- S_ID:
  - Illegal instruction: go to S_TRAP, set illegal.
  - jal/bltzal: go to S_WB.
  - All other instructions: go to S_EX.
- S_EX:
  - ALU ops: go to S_WB.
  - Loads/stores: go to S_MEM.
  - beq: pc_wr=zero, npc_sel=01.
  - j: pc_wr=1, npc_sel=10.
  - jr: pc_wr=1, npc_sel=11.
  - beq, j and jr go to S_IF and retire.
- S_MEM: mem_read=1 for loads, mem_write=1 for stores; byte_sel as decoded. Requests are held until mem_ready.
  - mem_ready with a store: go to S_IF and retire.
  - mem_ready with a load: go to S_WB.
- S_WB: reg_write=1 for every writing instruction; go to S_IF and retire.
  - jal: pc_wr=1, npc_sel=10.
  - bltzal: reg_write=1 always; pc_wr=neg, npc_sel=01.
- Retire: instr_count increments by 1 on each transition into S_IF from S_EX, S_MEM or S_WB. It wraps modulo 2^CNT_W.
- Watchdog:
  - The wait counter clears on every state change.
  - If TIMEOUT>0 and the counter reaches TIMEOUT-1 in S_IF or S_MEM while mem_ready=0, the next state is S_TRAP and timeout is set.
  - mem_ready=1 in that same cycle wins: normal transition, no trap.
- S_TRAP: absorbing until reset; all strobes 0; illegal/timeout held.
- Reset asserted mid-instruction (any state, including mid-wait) returns the block to S_IF immediately. No strobe fires in that cycle.

Test Plan:
- Reset then addu, mem_ready tied 1 -> states 0,1,2,4,0; reg_write=1 only in S_WB with reg_dst=01, alu_ctr=001; instr_count=1.
- lw, data mem_ready delayed 3 cycles (TIMEOUT=16) -> S_MEM held 4 cycles with mem_read=1, ifetch=0; then S_WB with mem_to_reg=01; total 8 cycles; count+1.
- beq with zero=0, then zero=1 -> pc_wr=0 then pc_wr=1 with npc_sel=01 in S_EX; both retire with no S_WB.
- bltzal with neg=0 and neg=1 -> reg_write=1, reg_dst=10, mem_to_reg=10 in S_WB both times; pc_wr equals neg.
- mem_ready held 0 in S_IF, TIMEOUT=16 -> S_TRAP after 16 cycles, timeout=1, all strobes 0 until reset; repeat with mem_ready=1 on cycle 16 -> no trap.
- opcode 6'b111111 (and lb with EN_BYTE=0) -> S_TRAP from S_ID, illegal=1; reset pulsed low mid-S_MEM -> state=0, counters/flags cleared, no mem_write.
